// File: rtl/aixh_mxc_inner_ptile_seq.sv
// aixh_mxc_inner_ptile_seq: job sequencer for one MxConv inner processing tile
// (weight load, skewed MAC wavefront, flush, backward-result drain).
module aixh_mxc_inner_ptile_seq #(
  parameter int YCELLS = 4,
  parameter int XCELLS = 4,
  parameter int CWIDTH = 2,
  parameter int LEN_W  = 12
) (
  input  logic                       aixh_core_clk2x,
  input  logic                       aixh_core_rstn,
  input  logic                       i_start,
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic                       o_w_req,
  input  logic                       i_w_vld,
  output logic                       o_a_rdy,
  input  logic                       i_a_vld,
  output logic [YCELLS*CWIDTH-1:0]   o_fwd_cmd,
  input  logic [YCELLS-1:0]          i_bwd_vld
);
  typedef enum logic [2:0] {IDLE, LOAD, MAC, FLUSH, DRAIN} state_t;
  localparam logic [CWIDTH-1:0] C_NOP   = CWIDTH'(0);
  localparam logic [CWIDTH-1:0] C_LOAD  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] C_MAC   = CWIDTH'(2);
  localparam logic [CWIDTH-1:0] C_FLUSH = CWIDTH'(3);

  if (YCELLS < 2 || XCELLS < 1 || CWIDTH < 2 || LEN_W < 1) begin : g_bad_params
    $error("aixh_mxc_inner_ptile_seq: unsupported parameter set");
  end

  state_t                           state_q, state_d;
  logic [LEN_W-1:0]                 len_q, len_d, w_cnt_q, w_cnt_d, a_cnt_q, a_cnt_d;
  logic [YCELLS-1:0]                seen_q, seen_d, seen_all;
  logic [YCELLS-2:0][CWIDTH-1:0]    skew_q, skew_d;
  logic [CWIDTH-1:0]                cmd0;
  logic                             finish;

  assign seen_all  = seen_q | i_bwd_vld;
  assign finish    = state_q == DRAIN && &seen_all && !i_abort;
  assign o_busy    = state_q != IDLE;
  assign o_err     = i_start && state_q != IDLE && !finish;
  assign o_fwd_cmd = {skew_q, cmd0};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    w_cnt_d = w_cnt_q;
    a_cnt_d = a_cnt_q;
    seen_d  = seen_q;
    cmd0    = C_NOP;
    o_w_req = 1'b0;
    o_a_rdy = 1'b0;
    o_done  = 1'b0;
    if (i_abort && state_q != IDLE) begin
      state_d = IDLE;
      w_cnt_d = '0;
      a_cnt_d = '0;
      seen_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          state_d = LOAD;
          len_d   = i_len;
        end
        LOAD: begin
          o_w_req = 1'b1;
          if (i_w_vld) begin
            cmd0    = C_LOAD;
            w_cnt_d = w_cnt_q + LEN_W'(!(&w_cnt_q));
            if (w_cnt_q == LEN_W'(YCELLS - 1)) state_d = len_q == '0 ? FLUSH : MAC;
          end
        end
        MAC: begin
          o_a_rdy = a_cnt_q < len_q;
          if (o_a_rdy && i_a_vld) begin
            cmd0    = C_MAC;
            a_cnt_d = a_cnt_q + LEN_W'(!(&a_cnt_q));
            if (a_cnt_q == len_q - LEN_W'(1)) state_d = FLUSH;
          end
        end
        FLUSH: begin
          cmd0    = C_FLUSH;
          state_d = DRAIN;
        end
        DRAIN: begin
          seen_d = seen_all;
          if (&seen_all) begin
            o_done  = 1'b1;
            seen_d  = '0;
            w_cnt_d = '0;
            a_cnt_d = '0;
            state_d = i_start ? LOAD : IDLE;
            len_d   = i_start ? i_len : len_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    skew_d[0] = cmd0;
    for (int i = 1; i < YCELLS - 1; i++) skew_d[i] = skew_q[i-1];
  end

  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      w_cnt_q <= '0;
      a_cnt_q <= '0;
      seen_q  <= '0;
      skew_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      w_cnt_q <= w_cnt_d;
      a_cnt_q <= a_cnt_d;
      seen_q  <= seen_d;
      skew_q  <= skew_d;
    end
  end
endmodule

// File: tb/tb_aixh_mxc_inner_ptile_seq.sv
// tb_aixh_mxc_inner_ptile_seq: scoreboard bench; the job driver predicts each
// cycle's outputs from the job script, a monitor compares them at negedge.
module tb_aixh_mxc_inner_ptile_seq;
  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start, i_abort, i_w_vld, i_a_vld;
  logic [11:0] i_len;
  logic [3:0]  i_bwd_vld;
  logic        o_busy, o_done, o_err, o_w_req, o_a_rdy;
  logic [7:0]  o_fwd_cmd;

  aixh_mxc_inner_ptile_seq dut (
    .aixh_core_clk2x(clk), .aixh_core_rstn(rstn), .i_start(i_start), .i_len(i_len),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_w_req(o_w_req), .i_w_vld(i_w_vld), .o_a_rdy(o_a_rdy), .i_a_vld(i_a_vld),
    .o_fwd_cmd(o_fwd_cmd), .i_bwd_vld(i_bwd_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] c0;
    logic wr, ar, dn, er, bz;
  } exp_t;
  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  logic [2:0][1:0] h;
  always @(negedge clk) begin
    if (!rstn) h = '0;
    else if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("row0", 32'(o_fwd_cmd[1:0]), 32'(e.c0));
      for (int y = 1; y < 4; y++) chk($sformatf("row%0d", y), 32'(o_fwd_cmd[y*2 +: 2]), 32'(h[y-1]));
      chk("w_req", 32'(o_w_req), 32'(e.wr));
      chk("a_rdy", 32'(o_a_rdy), 32'(e.ar));
      chk("done", 32'(o_done), 32'(e.dn));
      chk("err", 32'(o_err), 32'(e.er));
      chk("busy", 32'(o_busy), 32'(e.bz));
      h = {h[1], h[0], e.c0};
    end
  end

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic step(input logic [1:0] c0, input logic wr, ar, dn, er, bz);
    exp_t e;
    e.c0 = c0; e.wr = wr; e.ar = ar; e.dn = dn; e.er = er; e.bz = bz;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_start = 0; i_w_vld = 1'($urandom); i_a_vld = 1'($urandom); i_bwd_vld = 4'($urandom);
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  // ap < 0 toggles i_a_vld 1,0,1,0... over the MAC cycles; bmode selects the result pattern
  task automatic job(input int len, input int wp, input int ap, input int err_at, input int abort_at,
                     input int bmode, input bit pre, input bit chain, input int nlen);
    int n, k, mc, d;
    bit fired, fin;
    logic [3:0] seen, b;
    if (!pre) begin
      i_start = 1; i_len = 12'(len); i_bwd_vld = 4'($urandom);
      step(0, 0, 0, 0, 0, 0);
      i_start = 0;
    end
    n = 0; k = 0;
    while (n < 4) begin
      i_w_vld = rnd(wp) || k >= 8; i_a_vld = 1'($urandom); i_bwd_vld = 4'($urandom);
      step(i_w_vld ? 2'd1 : 2'd0, 1, 0, 0, 0, 1);
      if (i_w_vld) begin n++; k = 0; end else k++;
    end
    n = 0; k = 0; mc = 0; fired = 0;
    while (n < len) begin
      i_a_vld = ap < 0 ? !mc[0] : (rnd(ap) || k >= 8);
      i_w_vld = 1'($urandom); i_bwd_vld = 4'($urandom);
      i_start = !fired && n == err_at; i_len = 12'($urandom);
      if (n == abort_at) begin
        i_abort = 1;
        step(0, 0, 0, 0, i_start, 1);
        i_abort = 0; i_start = 0; i_bwd_vld = 0;
        return;
      end
      step(i_a_vld ? 2'd2 : 2'd0, 0, 1, 0, i_start, 1);
      if (i_start) fired = 1;
      i_start = 0;
      if (i_a_vld) begin n++; k = 0; end else k++;
      mc++;
    end
    i_bwd_vld = 4'($urandom);
    step(3, 0, 0, 0, 0, 1);
    seen = 0;
    for (d = 0; d < 40; d++) begin
      b = 0;
      if (bmode == 0) begin
        for (int y = 0; y < 4; y++) b[y] = d >= 20 || rnd(25);
      end else if (bmode == 1) begin
        for (int y = 0; y < 4; y++) b[y] = d == y + 4;
      end else begin
        b = d == 0 ? 4'b0001 : d == 1 ? 4'b0100 : d == 2 ? 4'b0010 : d == 3 ? 4'b0100 : d == 5 ? 4'b1000 : 4'b0000;
      end
      i_bwd_vld = b;
      fin = &(seen | b);
      i_start = fin && chain; i_len = 12'(nlen);
      step(0, 0, 0, fin, 0, 1);
      i_start = 0;
      seen |= b;
      if (fin) break;
    end
    i_bwd_vld = 0;
  endtask

  initial begin
    rstn = 0; i_start = 0; i_abort = 0; i_w_vld = 0; i_a_vld = 0; i_len = 0; i_bwd_vld = 0;
    #3;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_cmd", 32'(o_fwd_cmd), 0);
    chk("rst_wreq", 32'(o_w_req), 0);
    #9 rstn = 1;
    @(posedge clk); #1;
    idle(2);
    job(3, 100, 100, -1, -1, 1, 0, 0, 0);
    idle(1);
    job(3, 100, -1, -1, -1, 1, 0, 0, 0);
    job(0, 100, 100, -1, -1, 0, 0, 0, 0);
    job(5, 70, 60, 2, -1, 0, 0, 0, 0);
    job(6, 100, 100, -1, 1, 0, 0, 0, 0);
    job(4, 80, 80, -1, -1, 2, 0, 0, 0);
    job(2, 90, 90, -1, -1, 0, 0, 1, 7);
    job(7, 90, 90, -1, -1, 0, 1, 0, 0);
    i_start = 1; i_len = 5;
    step(0, 0, 0, 0, 0, 0);
    i_start = 0; i_w_vld = 1;
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    #2 rstn = 0;
    #1;
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_wreq", 32'(o_w_req), 0);
    chk("arst_cmd", 32'(o_fwd_cmd), 0);
    @(posedge clk); #2 rstn = 1;
    @(posedge clk); #1;
    idle(3);
    job(3, 60, 60, -1, -1, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      int len;
      len = $urandom_range(0, 20);
      job(len, $urandom_range(30, 100), $urandom_range(30, 100),
          rnd(30) ? $urandom_range(0, 20) : -1, rnd(25) ? $urandom_range(1, 20) : -1, 0, 0, 0, 0);
      idle($urandom_range(0, 2));
    end
    job(4095, 100, 100, -1, -1, 0, 0, 0, 0);
    idle(4);
    chk("queue_empty", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aixh_mxc_inner_ptile_seq.md
Name: aixh_mxc_inner_ptile_seq

Overview:
- Sequencer for one MxConv inner processing-tile.
- Runs one job: weight load, skewed MAC wavefront across the tile rows, flush, then waits for every row's backward result.
- Drives the tile's per-row forward command bus and handshakes with the weight source and the activation source.
- Sits between the MxConv inner control FSM and the processing-tile array.

Parameters:
- YCELLS, 4, tile rows; command skew depth.
- XCELLS, 4, tile columns; sets the flush-to-result window.
- CWIDTH, 2, per-row forward command width.
- LEN_W, 12, width of the MAC beat count.

Ports:
- aixh_core_clk2x  in  1  core clock; all logic rises on this edge.
- aixh_core_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  job start pulse; accepted only in IDLE.
- i_len  in  LEN_W  MAC beats for the job; sampled when i_start is accepted; 0 is legal.
- i_abort  in  1  synchronous abort.
- o_busy  out  1  high when the FSM is not in IDLE.
- o_done  out  1  one-cycle pulse when a job completes.
- o_err  out  1  one-cycle pulse on a start request that is ignored.
- o_w_req  out  1  weight-row request.
- i_w_vld  in  1  weight-row beat; it counts only while o_w_req is high.
- o_a_rdy  out  1  activation ready.
- i_a_vld  in  1  activation valid; a beat transfers when o_a_rdy and i_a_vld are both high.
- o_fwd_cmd  out  YCELLS*CWIDTH  row y uses bits [y*CWIDTH +: CWIDTH].
- i_bwd_vld  in  YCELLS  per-row result valid from the tile's backward output.

Behaviour:
- Command encoding: NOP=0, LOAD=1, MAC=2, FLUSH=3.
- Skew: row 0 carries the command generated this cycle. Row y carries the row-0 command delayed by y cycles, through a shift register of YCELLS-1 stages.
- Reset values: all outputs 0, all skew stages NOP, FSM in IDLE, all counters 0.
- IDLE:
  - i_start moves the FSM to LOAD next cycle and latches i_len.
- LOAD:
  - o_w_req=1.
  - Each i_w_vld beat drives LOAD on row 0 that cycle; a cycle without i_w_vld drives NOP.
  - After the YCELLS-th beat, go to MAC. If the latched length is 0, go to FLUSH instead.
- MAC:
  - o_a_rdy=1 while the beat count is below the latched length.
  - A transfer drives MAC on row 0; no transfer drives a NOP bubble.
  - The cycle after the final beat, go to FLUSH.
- FLUSH:
  - Row 0 carries FLUSH for exactly one cycle, then go to DRAIN.
- DRAIN:
  - Keep one sticky bit per row. A row's bit sets when its i_bwd_vld is seen.
  - When all bits are set, pulse o_done and return to IDLE. The next i_start is accepted in that same cycle.
  - A second i_bwd_vld on an already-set row is ignored.
  - i_bwd_vld outside DRAIN is ignored.
- o_err pulses for one cycle when i_start arrives in any state other than IDLE; the FSM is unaffected.
- Abort (any non-IDLE state): next cycle the FSM is in IDLE, counters and sticky bits clear, row 0 drives NOP, and o_done stays low. Commands already in the skew register keep draining; they are not flushed.
- i_abort has priority over i_start, i_w_vld and i_a_vld in the same cycle.
- Beat counters are LEN_W wide and saturate at their terminal count. A length of 2^LEN_W-1 runs fully with no wrap.
- Latency:
  - i_start to o_w_req is 1 cycle.
  - A row-0 command reaches row YCELLS-1 YCELLS-1 cycles later.
- Asynchronous reset mid-job returns all state immediately to the reset values.

Test Plan:
- YCELLS=4, i_len=3, i_w_vld and i_a_vld held high, each row's i_bwd_vld pulsed 5 cycles after its FLUSH:
  - o_busy rises 1 cycle after i_start.
  - Row 0 sequence: L,L,L,L,M,M,M,F.
  - Row 3 shows the same sequence 3 cycles later.
  - o_done pulses once after the row 3 result.
- i_a_vld toggling 1,0,1,0,1 with i_len=3: row 0 shows M,NOP,M,NOP,M; exactly 3 MAC commands issued.
- i_len=0: LOAD×4 then FLUSH, with no MAC and o_a_rdy never high.
- i_start during MAC: o_err pulses once; the job completes unchanged with its original beat count.
- i_abort in the 2nd MAC beat: next cycle o_busy=0 and row 0=NOP; rows 1-3 drain their pending commands; o_done never pulses; a following job runs normally.
- DRAIN with i_bwd_vld[2] pulsed twice and i_bwd_vld[0,1] once each: o_done stays low until i_bwd_vld[3] arrives.
- aixh_core_rstn asserted mid-LOAD: all outputs 0 immediately; after release the FSM sits idle until i_start.
